instruction_fetch_unit: RTL and testbench

- Bus-side consumer of the program counter.
- Enables the PC's tri-state address drivers, samples the shared 16-bit address bus, and issues a memory read with a req/ack handshake.
- Holds the returned instruction for the decode stage, then pulses the PC increment so the next fetch sees PC+1.
- Sits between the program counter, instruction memory and the decoder.

---
 rtl/instruction_fetch_unit_pkg.sv | 23 ++
 rtl/instruction_fetch_unit_if.sv | 44 ++++
 rtl/instruction_fetch_unit_timeout_ctr.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared constants for the instruction fetch unit
// Package ifu_pkg: FSM state encodings, default bus widths and the reset
// values of every registered output of instruction_fetch_unit.
package ifu_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Fetch FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRIVE = 3'd1;
    localparam logic [2:0] ST_REQ   = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_INC   = 3'd4;

    // Reset values of the registered outputs
    localparam logic RST_PC_OE_N     = 1'b1;
    localparam logic RST_PC_INC      = 1'b0;
    localparam logic RST_MEM_RD_REQ  = 1'b0;
    localparam logic RST_INSTR_VALID = 1'b0;
    localparam logic RST_FETCH_ERR   = 1'b0;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - PC / memory / decoder signal bundle of the fetch unit
// master : the fetch unit (drives pc_oe_n, pc_inc, mem_addr, mem_rd_req,
//          instr, instr_valid, fetch_err[, fetch_count]).
// slave  : the environment (PC, instruction memory, decoder, run control).
// fetch_count exists only when IFU_PERF_CNT_EN is defined.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              run;
    logic [ADDR_W-1:0] addr_bus;
    logic              pc_oe_n;
    logic              pc_inc;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_req;
    logic              mem_rd_ack;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              fetch_err;
`ifdef IFU_PERF_CNT_EN
    logic [15:0]       fetch_count;
`endif

    modport master (
        input  run, addr_bus, mem_rd_ack, mem_rd_data, instr_ready,
        output pc_oe_n, pc_inc, mem_addr, mem_rd_req, instr, instr_valid,
`ifdef IFU_PERF_CNT_EN
        output fetch_count,
`endif
        output fetch_err
    );

    modport slave (
        output run, addr_bus, mem_rd_ack, mem_rd_data, instr_ready,
        input  pc_oe_n, pc_inc, mem_addr, mem_rd_req, instr, instr_valid,
`ifdef IFU_PERF_CNT_EN
        input  fetch_count,
`endif
        input  fetch_err
    );

endinterface

// File: rtl/instruction_fetch_unit_timeout_ctr.sv
// rtl/instruction_fetch_unit_timeout_ctr.sv - clear/enable up-counter with expiry flag (ifu_timeout_ctr)
// Ports: clk, reset (async, active-high), clear (sync, to 0), en (count),
//        expired (count == LIMIT). The count holds at LIMIT once reached.
module ifu_timeout_ctr #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count;

    assign expired = (count == LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC-to-decoder instruction fetch sequencer
// Ports: clk, reset (async, active-high), bus (instruction_fetch_unit_if.master:
//        run, addr_bus, pc_oe_n, pc_inc, mem_addr, mem_rd_req/ack/data,
//        instr, instr_valid, instr_ready, fetch_err[, fetch_count]).
// Optional: IFU_PERF_CNT_EN adds a saturating 16-bit completed-fetch counter.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SETTLE_CYC  = 1,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_fetch_unit_if.master bus
);
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    logic [2:0]        state;
    logic              run_q;
    logic              pc_oe_n_q;
    logic              pc_inc_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_req_q;
    logic [DATA_W-1:0] instr_q;
    logic              instr_valid_q;
    logic              fetch_err_q;
    logic              settle_done;
    logic              ack_expired;

    // DRIVE lasts SETTLE_CYC cycles: the counter is zero on DRIVE entry and
    // the bus is sampled on the edge ending the cycle where it reads SETTLE_CYC-1.
    ifu_timeout_ctr #(.WIDTH(3), .LIMIT(SETTLE_CYC - 1)) u_settle (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ST_DRIVE),
        .en      (1'b1),
        .expired (settle_done)
    );

    // REQ cycle n (1-based) sees count n-1, so expiry marks the ACK_TIMEOUT-th cycle.
    ifu_timeout_ctr #(.WIDTH(ACK_W), .LIMIT(ACK_TIMEOUT - 1)) u_ack (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ST_REQ),
        .en      (!bus.mem_rd_ack),
        .expired (ack_expired)
    );

    // run is registered first; IDLE acts on the level sampled one edge earlier,
    // which gives the 5-cycle IDLE-DRIVE-REQ-HOLD-INC fetch period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            run_q         <= 1'b0;
            pc_oe_n_q     <= RST_PC_OE_N;
            pc_inc_q      <= RST_PC_INC;
            mem_addr_q    <= '0;
            mem_rd_req_q  <= RST_MEM_RD_REQ;
            instr_q       <= '0;
            instr_valid_q <= RST_INSTR_VALID;
            fetch_err_q   <= RST_FETCH_ERR;
        end else begin
            run_q <= bus.run;
            case (state)
                ST_IDLE: begin
                    if (run_q) begin
                        pc_oe_n_q <= 1'b0;
                        state     <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (settle_done) begin
                        mem_addr_q   <= bus.addr_bus;
                        pc_oe_n_q    <= 1'b1;
                        mem_rd_req_q <= 1'b1;
                        state        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // ack is checked first so a last-cycle ack is never an error
                    if (bus.mem_rd_ack) begin
                        instr_q       <= bus.mem_rd_data;
                        mem_rd_req_q  <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state         <= ST_HOLD;
                    end else if (ack_expired) begin
                        fetch_err_q  <= 1'b1;
                        mem_rd_req_q <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        pc_inc_q      <= 1'b1;
                        state         <= ST_INC;
                    end
                end
                ST_INC: begin
                    pc_inc_q <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [15:0] fetch_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
        end else if (state == ST_HOLD && bus.instr_ready && fetch_count_q != 16'hFFFF) begin
            fetch_count_q <= fetch_count_q + 16'd1;
        end
    end

    assign bus.fetch_count = fetch_count_q;
`endif

    assign bus.pc_oe_n     = pc_oe_n_q;
    assign bus.pc_inc      = pc_inc_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_rd_req  = mem_rd_req_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic reset;

    instruction_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) ifc ();

    instruction_fetch_unit #(
        .ADDR_W(16), .DATA_W(16), .SETTLE_CYC(1), .ACK_TIMEOUT(15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] pc = 16'h0000;
    logic        pc_load_req = 1'b0;
    logic [15:0] pc_load_val = 16'h0000;
    int          ack_delay = 0;
    logic        never_ack = 1'b0;
    int          req_cycles = 0;
    int          req_len = 0;
    int          last_req_len = 0;
    int          inc_count = 0;
    logic        prev_valid = 1'b0;

    // Tri-state PC and instruction memory (data = address + 0x1234)
    assign ifc.addr_bus    = ifc.pc_oe_n ? 16'hzzzz : pc;
    assign ifc.mem_rd_data = ifc.mem_addr + 16'h1234;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic load_pc(input logic [15:0] v);
        pc_load_val = v;
        pc_load_req = 1'b1;
        step();
        step();
        pc_load_req = 1'b0;
    endtask

    task automatic run_pulse();
        ifc.run = 1'b1;
        step();
        ifc.run = 1'b0;
    endtask

    task automatic wait_incs(input int target, input string tag);
        for (int i = 0; i < 60 && inc_count < target; i++) step();
        chk(tag, inc_count, target);
    endtask

    // PC model, memory responder and output monitor
    always @(negedge clk) begin
        if (pc_load_req) pc = pc_load_val;
        else if (ifc.pc_inc === 1'b1) pc = pc + 16'd1;

        if (ifc.mem_rd_req === 1'b1) req_cycles = req_cycles + 1;
        else req_cycles = 0;
        ifc.mem_rd_ack = (ifc.mem_rd_req === 1'b1) && !never_ack && (req_cycles == ack_delay + 1);

        if (ifc.mem_rd_req === 1'b1) begin
            req_len = req_len + 1;
        end else if (req_len != 0) begin
            last_req_len = req_len;
            req_len = 0;
        end

        if (!reset) begin
            if (ifc.pc_inc === 1'b1) inc_count = inc_count + 1;
            if (ifc.pc_oe_n === 1'b0 && ifc.pc_inc === 1'b1)
                chk("oe_inc_exclusive", 1, 0);
            if (ifc.instr_valid === 1'b1 && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_fetch", ifc.mem_addr, 16'hDEAD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_mem_addr", ifc.mem_addr, e.addr);
                    chk("sb_instr", ifc.instr, e.data);
                end
            end
        end
        prev_valid = (ifc.instr_valid === 1'b1);
    end

    initial begin
        int bad;
        int seen;
        reset = 1'b1;
        ifc.run = 1'b0;
        ifc.instr_ready = 1'b1;
        step();
        step();
        // ---- reset state
        chk("rst_pc_oe_n", ifc.pc_oe_n, 1);
        chk("rst_pc_inc", ifc.pc_inc, 0);
        chk("rst_mem_rd_req", ifc.mem_rd_req, 0);
        chk("rst_mem_addr", ifc.mem_addr, 0);
        chk("rst_instr", ifc.instr, 0);
        chk("rst_instr_valid", ifc.instr_valid, 0);
        chk("rst_fetch_err", ifc.fetch_err, 0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_fetch_count", ifc.fetch_count, 0);
`endif
        reset = 1'b0;
        load_pc(16'h0000);

        // ---- zero-wait fetch latency; run dropped during the second fetch
        push(16'h0000, 16'h1234);
        push(16'h0001, 16'h1235);
        ifc.run = 1'b1;
        step();                                    // cycle 0
        chk("c0_pc_oe_n", ifc.pc_oe_n, 1);
        step();                                    // cycle 1
        chk("c1_pc_oe_n", ifc.pc_oe_n, 0);
        chk("c1_mem_rd_req", ifc.mem_rd_req, 0);
        step();                                    // cycle 2
        chk("c2_pc_oe_n", ifc.pc_oe_n, 1);
        chk("c2_mem_rd_req", ifc.mem_rd_req, 1);
        chk("c2_mem_addr", ifc.mem_addr, 16'h0000);
        step();                                    // cycle 3
        chk("c3_instr_valid", ifc.instr_valid, 1);
        chk("c3_instr", ifc.instr, 16'h1234);
        chk("c3_mem_rd_req", ifc.mem_rd_req, 0);
        step();                                    // cycle 4
        chk("c4_pc_inc", ifc.pc_inc, 1);
        chk("c4_instr_valid", ifc.instr_valid, 0);
        step();                                    // cycle 5
        chk("c5_pc_inc", ifc.pc_inc, 0);
        ifc.run = 1'b0;
        step();                                    // cycle 6
        chk("c6_pc_oe_n", ifc.pc_oe_n, 0);
        step();                                    // cycle 7
        chk("c7_mem_addr", ifc.mem_addr, 16'h0001);
        wait_incs(2, "second_fetch_done");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ifc.pc_oe_n !== 1'b1 || ifc.mem_rd_req !== 1'b0) bad++;
        end
        chk("stays_idle_after_run_low", bad, 0);
        chk("stays_idle_inc_count", inc_count, 2);

        // ---- ack delayed by 5 cycles
        load_pc(16'h0002);
        ack_delay = 5;
        push(16'h0002, 16'h1236);
        run_pulse();
        wait_incs(3, "delayed_fetch_done");
        chk("delayed_req_len", last_req_len, 6);
        chk("delayed_no_err", ifc.fetch_err, 0);

        // ---- no ack: timeout, then refetch of the same address
        load_pc(16'h0003);
        never_ack = 1'b1;
        run_pulse();
        for (int i = 0; i < 40 && ifc.fetch_err !== 1'b1; i++) step();
        chk("timeout_fetch_err", ifc.fetch_err, 1);
        step();
        chk("timeout_req_len", last_req_len, 15);
        chk("timeout_no_inc", inc_count, 3);
        chk("timeout_req_low", ifc.mem_rd_req, 0);
        never_ack = 1'b0;
        ack_delay = 0;
        push(16'h0003, 16'h1237);
        run_pulse();
        wait_incs(4, "refetch_done");
        chk("fetch_err_sticky", ifc.fetch_err, 1);

        // ---- decoder stalls for 10 cycles
        ifc.instr_ready = 1'b0;
        push(16'h0004, 16'h1238);
        run_pulse();
        for (int i = 0; i < 20 && ifc.instr_valid !== 1'b1; i++) step();
        chk("stall_valid_seen", ifc.instr_valid, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (ifc.instr_valid !== 1'b1 || ifc.instr !== 16'h1238 || ifc.pc_inc !== 1'b0) bad++;
            step();
        end
        chk("stall_stable", bad, 0);
        ifc.instr_ready = 1'b1;
        step();
        chk("stall_release_pc_inc", ifc.pc_inc, 1);
        step();
        step();

        // ---- asynchronous reset during REQ
        never_ack = 1'b1;
        run_pulse();
        for (int i = 0; i < 20 && ifc.mem_rd_req !== 1'b1; i++) step();
        chk("pre_reset_req", ifc.mem_rd_req, 1);
        step();
        #2 reset = 1'b1;
        #1;
        chk("arst_mem_rd_req", ifc.mem_rd_req, 0);
        chk("arst_pc_oe_n", ifc.pc_oe_n, 1);
        chk("arst_instr_valid", ifc.instr_valid, 0);
        chk("arst_instr", ifc.instr, 0);
        chk("arst_mem_addr", ifc.mem_addr, 0);
        chk("arst_fetch_err", ifc.fetch_err, 0);
        chk("arst_pc_inc", ifc.pc_inc, 0);
        @(negedge clk);
        reset = 1'b0;
        never_ack = 1'b0;
        step();

        // ---- address wrap: 0xFFFF then 0x0000
        load_pc(16'hFFFF);
        push(16'hFFFF, 16'h1233);
        push(16'h0000, 16'h1234);
        ifc.run = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            step();
            if (ifc.pc_inc === 1'b1) seen++;
        end
        ifc.run = 1'b0;
        chk("wrap_two_incs", seen, 2);
        chk("wrap_last_addr", ifc.mem_addr, 16'h0000);
        for (int i = 0; i < 8; i++) step();
        chk("wrap_pc_model", pc, 16'h0001);
`ifdef IFU_PERF_CNT_EN
        chk("wrap_fetch_count", ifc.fetch_count, 2);
`endif
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
